// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: funct3 size codes, the FSM
// state type and the legal latency bounds.
package mem_resp_pkg;

    // funct3 size encodings used on req_size
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Response latency bounds; the wait counter is 4 bits wide.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Codes 011, 110 and 111 are not valid access sizes.
    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

endpackage

// File: rtl/mem_resp_lane.sv
// Byte-lane steering for the memory responder: positions store data and
// byte enables within the 32-bit word, and extracts/extends load data.
// The lane input is expected to be already aligned for H/W accesses.
module mem_resp_lane
    import mem_resp_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate the right-aligned data across the word and let
    // the byte enables pick which lanes actually get written.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        case (size)
            SZ_B, SZ_BU: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            SZ_W: begin
                be    = 4'b1111;
                wword = wdata;
            end
            default: be = 4'b0000;
        endcase
    end

    // Load side: select the addressed byte/half and sign- or zero-extend.
    always_comb begin
        byte_sel = rword[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rword[31:16] : rword[15:0];
        rdata    = 32'h0;
        case (size)
            SZ_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   rdata = {24'h0, byte_sel};
            SZ_H:    rdata = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   rdata = {16'h0, half_sel};
            SZ_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder for the core's load/store port. One request
// at a time is accepted in IDLE; the array access happens at the accepting
// edge and the registered result is presented after LATENCY cycles.
// Optional feature macro: MEM_RESP_MISALIGN_ERR_EN -- when defined,
// misaligned H/HU/W accesses fault; otherwise the low address bits are
// forced to natural alignment and the access proceeds.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Word array; deliberately not reset.
    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane_raw, lane_eff;
    logic                  range_err, size_err, mis_err, err;
    logic                  accept;
    logic [3:0]            be;
    logic [31:0]           wword, rdata_ext;

    // Address decode: anything outside the mapped window (including
    // addresses below base, which wrap to large offsets) faults.
    assign offset    = req_addr - BASE_ADDR;
    assign range_err = |offset[31:DEPTH_LOG2+2];
    assign idx       = offset[DEPTH_LOG2+1:2];
    assign lane_raw  = offset[1:0];
    assign size_err  = !size_legal(req_size);

    // Alignment handling: lane is forced to natural alignment for H/W, and
    // the misalignment fault is raised only when the feature is built in.
    always_comb begin
        lane_eff = lane_raw;
        mis_err  = 1'b0;
        case (req_size)
            SZ_H, SZ_HU: lane_eff = {lane_raw[1], 1'b0};
            SZ_W:        lane_eff = 2'b00;
            default:     lane_eff = lane_raw;
        endcase
`ifdef MEM_RESP_MISALIGN_ERR_EN
        if ((req_size == SZ_H || req_size == SZ_HU) && lane_raw[0])
            mis_err = 1'b1;
        if (req_size == SZ_W && lane_raw != 2'b00)
            mis_err = 1'b1;
`endif
    end

    assign err       = range_err | size_err | mis_err;
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    mem_resp_lane u_lane (
        .size  (req_size),
        .lane  (lane_eff),
        .wdata (req_wdata),
        .rword (mem[idx]),
        .be    (be),
        .wword (wword),
        .rdata (rdata_ext)
    );

    // Array write at the accepting edge for legal stores, byte-enabled.
    always_ff @(posedge clk) begin
        if (accept && req_wen && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // Capture the response at acceptance; stores and faults return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= err;
            rdata_q <= (req_wen || err) ? 32'h0 : rdata_ext;
        end
    end

    // Latency counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 4'd0;
        else if (accept)
            cnt_q <= CNT_LOAD;
        else if (state_q == ST_WAIT && cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2, default base
// and depth). Expected values are hand-computed constants.
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_size = 3'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd, w10;
    logic        er;

    mem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; checks handshake timing and returns the response.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdo, output logic ero);
        int n;
        n = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size; req_wdata = wdata;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("wait_resp_valid", 32'(resp_valid), 32'd0);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("resp_valid_at_latency", 32'(resp_valid), 32'd1);
        rdo = resp_rdata;
        ero = resp_err;
        if (resp_ready) begin
            step();
            chk("consumed_resp_valid", 32'(resp_valid), 32'd0);
            chk("consumed_req_ready", 32'(req_ready), 32'd1);
        end
    endtask

    task automatic access(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] r;
        logic        e;
        txn(wen, addr, size, wdata, r, e);
        chk({tag, "_rdata"}, r, exp_rd);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    initial begin
        // Reset held with a pending request: nothing may be accepted.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE; req_size = SZ_W; req_wdata = 32'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Word store/load round trip.
        access("st_w", 1'b1, 32'h8000_0010, SZ_W, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("ld_w", 1'b0, 32'h8000_0010, SZ_W, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte store into lane 3; upper wdata bits must be ignored.
        access("st_b", 1'b1, 32'h8000_0013, SZ_B, 32'hAAAA_AA80, 32'h0, 1'b0);
        access("ld_b", 1'b0, 32'h8000_0013, SZ_B, 32'h0, 32'hFFFF_FF80, 1'b0);
        access("ld_bu", 1'b0, 32'h8000_0013, SZ_BU, 32'h0, 32'h0000_0080, 1'b0);
        access("ld_w_after_b", 1'b0, 32'h8000_0010, SZ_W, 32'h0, 32'h80AD_BEEF, 1'b0);
        access("ld_hu_hi", 1'b0, 32'h8000_0012, SZ_HU, 32'h0, 32'h0000_80AD, 1'b0);
        access("ld_h_hi", 1'b0, 32'h8000_0012, SZ_H, 32'h0, 32'hFFFF_80AD, 1'b0);

        // Out-of-range accesses: below base aliases the last word, one past
        // the end aliases word 0; neither may be written.
        access("st_last", 1'b1, 32'h8000_3FFC, SZ_W, 32'h1234_5678, 32'h0, 1'b0);
        access("st_first", 1'b1, 32'h8000_0000, SZ_W, 32'hCAFE_F00D, 32'h0, 1'b0);
        access("ld_below", 1'b0, 32'h7FFF_FFFC, SZ_W, 32'h0, 32'h0, 1'b1);
        access("ld_above", 1'b0, 32'h8000_4000, SZ_W, 32'h0, 32'h0, 1'b1);
        access("st_below", 1'b1, 32'h7FFF_FFFC, SZ_W, 32'h1111_1111, 32'h0, 1'b1);
        access("st_above", 1'b1, 32'h8000_4000, SZ_W, 32'h2222_2222, 32'h0, 1'b1);
        access("ld_last_kept", 1'b0, 32'h8000_3FFC, SZ_W, 32'h0, 32'h1234_5678, 1'b0);
        access("ld_first_kept", 1'b0, 32'h8000_0000, SZ_W, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Illegal size codes fault.
        access("ld_sz011", 1'b0, 32'h8000_0010, 3'b011, 32'h0, 32'h0, 1'b1);
        access("st_sz111", 1'b1, 32'h8000_0010, 3'b111, 32'hFFFF_FFFF, 32'h0, 1'b1);

        // Misaligned half load, then aligned and misaligned half stores.
`ifdef MEM_RESP_MISALIGN_ERR_EN
        access("ld_h_mis", 1'b0, 32'h8000_0011, SZ_H, 32'h0, 32'h0, 1'b1);
`else
        access("ld_h_mis", 1'b0, 32'h8000_0011, SZ_H, 32'h0, 32'hFFFF_BEEF, 1'b0);
`endif
        access("st_h_hi", 1'b1, 32'h8000_0012, SZ_H, 32'hFFFF_1234, 32'h0, 1'b0);
`ifdef MEM_RESP_MISALIGN_ERR_EN
        access("st_h_mis", 1'b1, 32'h8000_0011, SZ_H, 32'h0000_5678, 32'h0, 1'b1);
        w10 = 32'h1234_BEEF;
`else
        access("st_h_mis", 1'b1, 32'h8000_0011, SZ_H, 32'h0000_5678, 32'h0, 1'b0);
        w10 = 32'h1234_5678;
`endif
        access("ld_w_after_h", 1'b0, 32'h8000_0010, SZ_W, 32'h0, w10, 1'b0);

        // Back-pressure: response held for 5 cycles while a store is offered.
        resp_ready = 1'b0;
        txn(1'b0, 32'h8000_0010, SZ_W, 32'h0, rd, er);
        chk("hold_first_rdata", rd, w10);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
        req_size = SZ_W; req_wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, w10);
            chk("hold_err", 32'(resp_err), 32'd0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        chk("release_resp_valid", 32'(resp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        access("ld_after_hold", 1'b0, 32'h8000_0010, SZ_W, 32'h0, w10, 1'b0);

        // Reset during WAIT: response dropped, committed store survives.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
        req_size = SZ_W; req_wdata = 32'h55AA_55AA;
        step();
        req_valid = 1'b0;
        chk("midrst_in_wait", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_resp_valid_after", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
        access("ld_after_midrst", 1'b0, 32'h8000_0020, SZ_W, 32'h0, 32'h55AA_55AA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
